// File: rtl/envelope_controller.sv
// ADSR envelope controller: latches note parameters for the tone generator and
// steps the amplitude through attack/decay/sustain/release on env_tick strobes.
module envelope_controller #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              note_on,
    input  logic              note_off,
    input  logic [15:0]       note_freq,
    input  logic [1:0]        note_waveform,
    input  logic [11:0]       note_pulse_width,
    input  logic              env_tick,
    input  logic [STEP_W-1:0] attack_step,
    input  logic [STEP_W-1:0] decay_step,
    input  logic [STEP_W-1:0] release_step,
    input  logic [STEP_W-1:0] sustain_level,
    output logic [15:0]       tone_freq,
    output logic [1:0]        waveform_select,
    output logic [11:0]       pulse_width,
    output logic [STEP_W-1:0] amplitude,
    output logic [2:0]        state,
    output logic              active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [STEP_W:0] MAX_W = {1'b0, {STEP_W{1'b1}}};

    state_t            state_q, state_d;
    logic [STEP_W-1:0] amp_q, amp_d;
    logic [15:0]       freq_q, freq_d;
    logic [1:0]        wave_q, wave_d;
    logic [11:0]       pw_q, pw_d;

    logic [STEP_W:0]   att_sum;
    logic [STEP_W-1:0] att_amp;
    logic [STEP_W-1:0] dec_floor;
    logic [STEP_W-1:0] dec_amp;
    logic [STEP_W-1:0] rel_amp;

    // Candidate amplitudes per phase; a zero step means jump straight to the target.
    always_comb begin
        att_sum = {1'b0, amp_q} + {1'b0, attack_step};
        if (attack_step == '0 || att_sum > MAX_W) begin
            att_amp = '1;
        end else begin
            att_amp = att_sum[STEP_W-1:0];
        end

        if (decay_step == '0 || amp_q < decay_step) begin
            dec_floor = '0;
        end else begin
            dec_floor = amp_q - decay_step;
        end
        dec_amp = (dec_floor > sustain_level) ? dec_floor : sustain_level;

        if (release_step == '0 || amp_q <= release_step) begin
            rel_amp = '0;
        end else begin
            rel_amp = amp_q - release_step;
        end
    end

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        freq_d  = freq_q;
        wave_d  = wave_q;
        pw_d    = pw_q;

        if (state_q > RELEASE) begin
            state_d = IDLE;
            amp_d   = '0;
        end else if (note_on) begin
            // Retrigger keeps the current amplitude so the attack starts click-free.
            state_d = ATTACK;
            freq_d  = note_freq;
            wave_d  = note_waveform;
            pw_d    = note_pulse_width;
        end else if (note_off && (state_q == ATTACK || state_q == DECAY ||
                                  state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (env_tick) begin
            case (state_q)
                ATTACK: begin
                    amp_d = att_amp;
                    if (att_amp == '1) state_d = DECAY;
                end
                DECAY: begin
                    amp_d = dec_amp;
                    if (dec_amp == sustain_level) state_d = SUSTAIN;
                end
                SUSTAIN: amp_d = sustain_level;
                RELEASE: begin
                    amp_d = rel_amp;
                    if (rel_amp == '0) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            amp_q   <= '0;
            freq_q  <= '0;
            wave_q  <= '0;
            pw_q    <= '0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            freq_q  <= freq_d;
            wave_q  <= wave_d;
            pw_q    <= pw_d;
        end
    end

    assign tone_freq       = freq_q;
    assign waveform_select = wave_q;
    assign pulse_width     = pw_q;
    assign amplitude       = amp_q;
    assign state           = state_q;
    assign active          = (state_q != IDLE);

endmodule

// File: tb/tb_envelope_controller.sv
// Directed and randomized bench for envelope_controller against an integer ADSR model.
module tb_envelope_controller;

    logic        clk;
    logic        rst;
    logic        note_on, note_off, env_tick;
    logic [15:0] note_freq;
    logic [1:0]  note_waveform;
    logic [11:0] note_pulse_width;
    logic [7:0]  attack_step, decay_step, release_step, sustain_level;
    logic [15:0] tone_freq;
    logic [1:0]  waveform_select;
    logic [11:0] pulse_width;
    logic [7:0]  amplitude;
    logic [2:0]  state;
    logic        active;

    int checks = 0;
    int failures = 0;

    int m_state, m_amp, m_freq, m_wave, m_pw;

    envelope_controller #(.STEP_W(8)) dut (
        .clk(clk), .rst(rst),
        .note_on(note_on), .note_off(note_off),
        .note_freq(note_freq), .note_waveform(note_waveform),
        .note_pulse_width(note_pulse_width), .env_tick(env_tick),
        .attack_step(attack_step), .decay_step(decay_step),
        .release_step(release_step), .sustain_level(sustain_level),
        .tone_freq(tone_freq), .waveform_select(waveform_select),
        .pulse_width(pulse_width), .amplitude(amplitude),
        .state(state), .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".active"}, 32'(active), 32'(m_state != 0));
        chk({tag, ".amplitude"}, 32'(amplitude), 32'(m_amp));
        chk({tag, ".tone_freq"}, 32'(tone_freq), 32'(m_freq));
        chk({tag, ".waveform"}, 32'(waveform_select), 32'(m_wave));
        chk({tag, ".pulse_width"}, 32'(pulse_width), 32'(m_pw));
    endtask

    task automatic model_reset();
        m_state = 0; m_amp = 0; m_freq = 0; m_wave = 0; m_pw = 0;
    endtask

    // ADSR rules in plain integer arithmetic: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    task automatic model_step();
        int a, d, r, s;
        a = int'(attack_step); d = int'(decay_step);
        r = int'(release_step); s = int'(sustain_level);
        if (note_on) begin
            m_state = 1;
            m_freq = int'(note_freq); m_wave = int'(note_waveform); m_pw = int'(note_pulse_width);
        end else if (note_off && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (env_tick) begin
            if (m_state == 1) begin
                m_amp = (a == 0 || m_amp + a > 255) ? 255 : m_amp + a;
                if (m_amp == 255) m_state = 2;
            end else if (m_state == 2) begin
                m_amp = (d == 0 || m_amp - d < s) ? s : m_amp - d;
                if (m_amp == s) m_state = 3;
            end else if (m_state == 3) begin
                m_amp = s;
            end else if (m_state == 4) begin
                m_amp = (r == 0 || m_amp - r < 0) ? 0 : m_amp - r;
                if (m_amp == 0) m_state = 0;
            end
        end
    endtask

    task automatic cyc(input bit on, input bit off, input bit tick, input string tag);
        note_on = on; note_off = off; env_tick = tick;
        model_step();
        @(posedge clk);
        #1;
        note_on = 1'b0; note_off = 1'b0; env_tick = 1'b0;
        check_all(tag);
    endtask

    task automatic set_steps(input int a, input int d, input int s, input int r);
        attack_step = 8'(a); decay_step = 8'(d);
        sustain_level = 8'(s); release_step = 8'(r);
    endtask

    task automatic set_note(input int f, input int w, input int p);
        note_freq = 16'(f); note_waveform = 2'(w); note_pulse_width = 12'(p);
    endtask

    initial begin
        int exp_dec [8] = '{239, 223, 207, 191, 175, 159, 143, 128};
        int exp_rel [4] = '{96, 64, 32, 0};

        rst = 1'b1;
        note_on = 0; note_off = 0; env_tick = 0;
        set_note(16'hBEEF, 2, 12'h5A5);
        set_steps(64, 16, 128, 32);
        model_reset();
        #3;
        check_all("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        rst = 1'b0;

        // Full ADSR
        set_note(16'h1234, 3, 12'h200);
        cyc(1, 0, 0, "adsr_on");
        chk("adsr_on_freq", 32'(tone_freq), 32'h1234);
        chk("adsr_on_state", 32'(state), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, "adsr_attack");
            cyc(0, 0, 0, "adsr_hold");
        end
        chk("adsr_peak", 32'(amplitude), 255);
        chk("adsr_peak_state", 32'(state), 2);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, "adsr_decay");
            chk("adsr_decay_amp", 32'(amplitude), 32'(exp_dec[i]));
        end
        chk("adsr_sustain_state", 32'(state), 3);
        cyc(0, 1, 0, "adsr_off");
        chk("adsr_release_state", 32'(state), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, "adsr_release");
            chk("adsr_release_amp", 32'(amplitude), 32'(exp_rel[i]));
        end
        chk("adsr_idle_active", 32'(active), 0);
        chk("adsr_idle_freq", 32'(tone_freq), 32'h1234);

        // Retrigger from release at 96
        cyc(1, 0, 0, "retrig_on");
        repeat (12) cyc(0, 0, 1, "retrig_climb");
        chk("retrig_sustain", 32'(state), 3);
        cyc(0, 1, 0, "retrig_off");
        cyc(0, 0, 1, "retrig_rel");
        chk("retrig_rel_amp", 32'(amplitude), 96);
        set_note(16'h0777, 1, 12'h0FF);
        cyc(1, 0, 0, "retrig_note");
        chk("retrig_state", 32'(state), 1);
        chk("retrig_amp", 32'(amplitude), 96);
        cyc(0, 0, 1, "retrig_tick");
        chk("retrig_tick_amp", 32'(amplitude), 160);

        // Collision in sustain
        repeat (10) cyc(0, 0, 1, "coll_climb");
        chk("coll_pre_state", 32'(state), 3);
        set_note(16'hABCD, 2, 12'h3C3);
        cyc(1, 1, 1, "coll");
        chk("coll_state", 32'(state), 1);
        chk("coll_amp", 32'(amplitude), 128);
        chk("coll_freq", 32'(tone_freq), 32'hABCD);

        // Zero steps
        set_steps(0, 0, 50, 0);
        cyc(1, 0, 0, "zero_on");
        cyc(0, 0, 1, "zero_attack");
        chk("zero_attack_amp", 32'(amplitude), 255);
        cyc(0, 0, 1, "zero_decay");
        chk("zero_decay_amp", 32'(amplitude), 50);
        chk("zero_decay_state", 32'(state), 3);
        cyc(0, 1, 0, "zero_off");
        cyc(0, 0, 1, "zero_release");
        chk("zero_release_amp", 32'(amplitude), 0);
        chk("zero_release_state", 32'(state), 0);

        // Asynchronous reset in decay
        set_steps(64, 16, 128, 32);
        cyc(1, 0, 0, "arst_on");
        repeat (5) cyc(0, 0, 1, "arst_climb");
        chk("arst_pre_state", 32'(state), 2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst_mid");
        #2;
        rst = 1'b0;
        cyc(0, 0, 0, "arst_after");
        cyc(1, 0, 0, "arst_note");
        cyc(0, 0, 1, "arst_tick");
        chk("arst_from_zero", 32'(amplitude), 64);

        // Ignored events in idle
        set_steps(64, 16, 128, 0);
        cyc(0, 1, 0, "ign_off");
        cyc(0, 0, 1, "ign_rel");
        chk("ign_idle", 32'(state), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, (i % 2) == 0, 1, "ignored");
            chk("ignored_amp", 32'(amplitude), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                set_steps(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 100),
                          ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 100),
                          $urandom_range(0, 255),
                          ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 100));
            end
            set_note($urandom_range(0, 65535), $urandom_range(0, 3), $urandom_range(0, 4095));
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 4, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
